// File: rtl/alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter
//
// Purpose:
//   Two requesters share one combinational MIPS-style ALU through this block.
//   Only one operation is in flight at a time. For each operation the block:
//     1. picks a requester round-robin while it is idle,
//     2. captures the winner's opcode/func/operands into the alu_* registers,
//     3. holds them on the ALU for EXEC_CYCLES cycles,
//     4. samples the ALU result/zero into the response registers, and
//     5. holds the response, tagged with the requester ID, until it is consumed.
//
// Parameters:
//   WIDTH        operand/result width
//   EXEC_CYCLES  cycles the ALU inputs are held before the result is sampled
//                (must be >= 1)
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   rN_valid/rN_ready     requester N handshake (N = 0, 1); ready is
//                         combinational and only asserted while idle
//   rN_opcode/rN_func     requester N operation encoding
//   rN_a/rN_b             requester N operands
//   rsp_valid/rsp_ready   response handshake
//   rsp_id                requester that issued the returned operation
//   rsp_result/rsp_zero   captured ALU outputs
//   alu_opcode/alu_func_field/alu_a/alu_b   registered drive to the ALU
//   alu_result/alu_zero   combinational return from the ALU
//
// Timing:
//   Handshake in cycle T -> rsp_valid high from cycle T+EXEC_CYCLES+1.
//   Accepts are at least EXEC_CYCLES+2 cycles apart.
// -----------------------------------------------------------------------------
module alu_share_arbiter #(
  parameter int WIDTH       = 32,
  parameter int EXEC_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [5:0]       r0_opcode,
  input  logic [5:0]       r0_func,
  input  logic [WIDTH-1:0] r0_a,
  input  logic [WIDTH-1:0] r0_b,

  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [5:0]       r1_opcode,
  input  logic [5:0]       r1_func,
  input  logic [WIDTH-1:0] r1_a,
  input  logic [WIDTH-1:0] r1_b,

  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,

  output logic [5:0]       alu_opcode,
  output logic [5:0]       alu_func_field,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero
);

  // The counter has to hold the value EXEC_CYCLES, which it reaches when
  // it increments on the final EXEC cycle, so it never wraps.
  localparam int            CW       = $clog2(EXEC_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(EXEC_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             id_q, id_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [5:0]       alu_opcode_q, alu_opcode_d;
  logic [5:0]       alu_func_q, alu_func_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;

  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_zero_q, rsp_zero_d;

  logic             grant;
  logic             accept;

  // ---------------------------------------------------------------------------
  // Round-robin choice. A lone requester always wins. When both are valid,
  // the one that did not win last time wins. With neither valid the value
  // is irrelevant because both readies are gated by their valids.
  // ---------------------------------------------------------------------------
  always_comb begin
    grant = 1'b0;
    if (r0_valid && r1_valid) begin
      grant = ~last_grant_q;
    end else if (r1_valid) begin
      grant = 1'b1;
    end
  end

  // rst_n gates the readies so that no requester sees an accept while the
  // block is held in reset.
  assign r0_ready = rst_n && (state_q == ST_IDLE) && r0_valid && !grant;
  assign r1_ready = rst_n && (state_q == ST_IDLE) && r1_valid &&  grant;
  assign accept   = r0_ready || r1_ready;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    cnt_d        = cnt_q;
    alu_opcode_d = alu_opcode_q;
    alu_func_d   = alu_func_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          alu_opcode_d = grant ? r1_opcode : r0_opcode;
          alu_func_d   = grant ? r1_func   : r0_func;
          alu_a_d      = grant ? r1_a      : r0_a;
          alu_b_d      = grant ? r1_b      : r0_b;
          id_d         = grant;
          last_grant_d = grant;
          cnt_d        = '0;
          state_d      = ST_EXEC;
        end
      end

      ST_EXEC: begin
        // The ALU inputs stay as latched. Its outputs are sampled on the
        // last EXEC cycle, so the ALU gets EXEC_CYCLES full cycles to settle.
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          rsp_result_d = alu_result;
          rsp_zero_d   = alu_zero;
          rsp_id_d     = id_q;
          rsp_valid_d  = 1'b1;
          state_d      = ST_RESP;
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers. last_grant resets to 1 so that requester 0 wins the first
  // contested arbitration.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      cnt_q        <= '0;
      alu_opcode_q <= '0;
      alu_func_q   <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      cnt_q        <= cnt_d;
      alu_opcode_q <= alu_opcode_d;
      alu_func_q   <= alu_func_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
    end
  end

  assign alu_opcode     = alu_opcode_q;
  assign alu_func_field = alu_func_q;
  assign alu_a          = alu_a_q;
  assign alu_b          = alu_b_q;

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_share_arbiter
//   Bench for alu_share_arbiter. It instantiates one DUT with EXEC_CYCLES=1 and
//   a second with EXEC_CYCLES=3, each driving a behavioural MIPS-style ALU.
//   Directed scenario tasks run first, then a randomized run checked against
//   a transaction-level model (one outstanding op, round-robin rule, latency).
// -----------------------------------------------------------------------------
module tb_alu_share_arbiter;
  localparam int W = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors     = 0;
  int miscompares = 0;

  // ---------------- DUT A (EXEC_CYCLES = 1) ----------------
  logic         r0_valid = 0, r1_valid = 0, r0_ready, r1_ready;
  logic [5:0]   r0_opcode = 0, r0_func = 0, r1_opcode = 0, r1_func = 0;
  logic [W-1:0] r0_a = 0, r0_b = 0, r1_a = 0, r1_b = 0;
  logic         rsp_valid, rsp_ready = 0, rsp_id, rsp_zero;
  logic [W-1:0] rsp_result;
  logic [5:0]   alu_opcode, alu_func_field;
  logic [W-1:0] alu_a, alu_b, alu_result;
  logic         alu_zero;

  // ---------------- DUT B (EXEC_CYCLES = 3) ----------------
  logic         c_r0_valid = 0, c_r0_ready, c_r1_ready;
  logic [5:0]   c_r0_opcode = 0, c_r0_func = 0;
  logic [W-1:0] c_r0_a = 0, c_r0_b = 0;
  logic         c_rsp_valid, c_rsp_ready = 1, c_rsp_id, c_rsp_zero;
  logic [W-1:0] c_rsp_result;
  logic [5:0]   c_alu_opcode, c_alu_func_field;
  logic [W-1:0] c_alu_a, c_alu_b, c_alu_result;
  logic         c_alu_zero;

  // Behavioural ALU: returns {result, zero}.
  function automatic logic [W:0] alu_fn(input logic [5:0] op, input logic [5:0] fn,
                                        input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    r = '0;
    if (op == 6'h00) begin
      case (fn)
        6'h20, 6'h21: r = a + b;
        6'h22, 6'h23: r = a - b;
        6'h24:        r = a & b;
        6'h25:        r = a | b;
        6'h26:        r = a ^ b;
        6'h27:        r = ~(a | b);
        6'h2A:        r = ($signed(a) < $signed(b)) ? W'(1) : '0;
        6'h2B:        r = (a < b) ? W'(1) : '0;
        default:      r = '0;
      endcase
    end else if (op == 6'h04 || op == 6'h05) begin
      r = a - b;
    end
    return {r, (r == '0)};
  endfunction

  assign {alu_result, alu_zero}     = alu_fn(alu_opcode, alu_func_field, alu_a, alu_b);
  assign {c_alu_result, c_alu_zero} = alu_fn(c_alu_opcode, c_alu_func_field, c_alu_a, c_alu_b);

  alu_share_arbiter #(.WIDTH(W), .EXEC_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_opcode(r0_opcode), .r0_func(r0_func),
    .r0_a(r0_a), .r0_b(r0_b),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_opcode(r1_opcode), .r1_func(r1_func),
    .r1_a(r1_a), .r1_b(r1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .alu_opcode(alu_opcode), .alu_func_field(alu_func_field), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_zero(alu_zero)
  );

  alu_share_arbiter #(.WIDTH(W), .EXEC_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(c_r0_valid), .r0_ready(c_r0_ready), .r0_opcode(c_r0_opcode), .r0_func(c_r0_func),
    .r0_a(c_r0_a), .r0_b(c_r0_b),
    .r1_valid(1'b0), .r1_ready(c_r1_ready), .r1_opcode(6'd0), .r1_func(6'd0),
    .r1_a({W{1'b0}}), .r1_b({W{1'b0}}),
    .rsp_valid(c_rsp_valid), .rsp_ready(c_rsp_ready), .rsp_id(c_rsp_id),
    .rsp_result(c_rsp_result), .rsp_zero(c_rsp_zero),
    .alu_opcode(c_alu_opcode), .alu_func_field(c_alu_func_field), .alu_a(c_alu_a), .alu_b(c_alu_b),
    .alu_result(c_alu_result), .alu_zero(c_alu_zero)
  );

  // Operation table for random stimulus.
  logic [5:0] op_tab [12] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                               6'h00, 6'h00, 6'h00, 6'h00, 6'h04, 6'h05};
  logic [5:0] fn_tab [12] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                               6'h26, 6'h27, 6'h2A, 6'h2B, 6'h00, 6'h00};

  // ---------------- stimulus helpers (no checking inside) ----------------
  task automatic set_req(input int n, input logic v, input logic [5:0] op, input logic [5:0] fn,
                         input logic [W-1:0] a, input logic [W-1:0] b);
    if (n == 0) begin
      r0_valid = v; r0_opcode = op; r0_func = fn; r0_a = a; r0_b = b;
    end else if (n == 1) begin
      r1_valid = v; r1_opcode = op; r1_func = fn; r1_a = a; r1_b = b;
    end else begin
      c_r0_valid = v; c_r0_opcode = op; c_r0_func = fn; c_r0_a = a; c_r0_b = b;
    end
  endtask

  task automatic rand_req(input int n);
    int k;
    logic [W-1:0] a, b;
    k = $urandom_range(0, 11);
    a = $urandom;
    b = ($urandom_range(0, 3) == 0) ? a : W'($urandom);
    set_req(n, 1'b1, op_tab[k], fn_tab[k], a, b);
  endtask

  // Waits (bounded) at negedges for ready of requester n (2 = DUT B r0).
  task automatic wait_ready(input int n, output int t, output bit ok);
    ok = 0; t = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ((n == 0 && r0_ready) || (n == 1 && r1_ready) || (n == 2 && c_r0_ready)) begin
        ok = 1; t = cyc; return;
      end
    end
  endtask

  task automatic wait_rsp(output int t, output bit ok);
    ok = 0; t = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_valid) begin ok = 1; t = cyc; return; end
    end
  endtask

  task automatic apply_reset();
    r0_valid = 0; r1_valid = 0; c_r0_valid = 0; rsp_ready = 0;
    #1 rst_n = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    r0_valid = 1; r1_valid = 1;
    #1 rst_n = 0;
    @(negedge clk);
    vectors++;
    if ({r0_ready, r1_ready} !== 2'b00) begin
      miscompares++; $display("FAIL rst_ready: got %b want 00", {r0_ready, r1_ready});
    end
    vectors++;
    if ({rsp_valid, rsp_id, rsp_zero, rsp_result} !== '0) begin
      miscompares++; $display("FAIL rst_rsp: got v=%b id=%b z=%b r=%h want all 0", rsp_valid, rsp_id, rsp_zero, rsp_result);
    end
    vectors++;
    if ({alu_opcode, alu_func_field, alu_a, alu_b} !== '0) begin
      miscompares++; $display("FAIL rst_alu: got op=%h fn=%h a=%h b=%h want all 0", alu_opcode, alu_func_field, alu_a, alu_b);
    end
    r0_valid = 0; r1_valid = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic test_single(input int n, input logic [5:0] op, input logic [5:0] fn,
                             input logic [W-1:0] exp_res, input logic exp_zero);
    int t0, t, tr; bit ok, ok2;
    rsp_ready = 1;
    @(posedge clk); #1;
    set_req(n, 1'b1, op, fn, 32'h2222, 32'h1111);
    t0 = cyc;
    wait_ready(n, t, ok);
    vectors++;
    if (!ok || t != t0) begin
      miscompares++; $display("FAIL single%0d_accept: got cycle %0d want %0d", n, t, t0);
    end
    @(posedge clk); #1;
    set_req(n, 1'b0, op, fn, 32'h2222, 32'h1111);
    wait_rsp(tr, ok2);
    vectors++;
    if (!ok2 || tr != t + 2) begin
      miscompares++; $display("FAIL single%0d_latency: got cycle %0d want %0d", n, tr, t + 2);
    end
    vectors++;
    if ({rsp_id, rsp_zero, rsp_result} !== {n[0], exp_zero, exp_res}) begin
      miscompares++; $display("FAIL single%0d_rsp: got id=%b z=%b r=%h want id=%0d z=%b r=%h", n, rsp_id, rsp_zero, rsp_result, n, exp_zero, exp_res);
    end
    $display("txn r%0d op=%h fn=%h -> id=%b result=%h zero=%b", n, op, fn, rsp_id, rsp_result, rsp_zero);
    @(negedge clk);
    vectors++;
    if ({rsp_valid, rsp_result, alu_a, alu_b} !== {1'b0, exp_res, 32'h2222, 32'h1111}) begin
      miscompares++; $display("FAIL single%0d_hold: got v=%b r=%h a=%h b=%h want v=0 r=%h a=2222 b=1111", n, rsp_valid, rsp_result, alu_a, alu_b, exp_res);
    end
  endtask

  task automatic test_round_robin();
    int grants, rsps;
    bit last, g;
    int exp_ids[$];
    apply_reset();
    rsp_ready = 1;
    set_req(0, 1'b1, 6'h04, 6'h00, 32'h5555, 32'h5555);
    set_req(1, 1'b1, 6'h00, 6'h2A, 32'h1111, 32'h2222);
    last = 1; grants = 0; rsps = 0;
    for (int i = 0; i < 60 && rsps < 4; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        vectors++;
        if (exp_ids.size() == 0 || rsp_id !== exp_ids[0] ||
            rsp_result !== (rsp_id ? 32'h1 : 32'h0) || rsp_zero !== !rsp_id) begin
          miscompares++; $display("FAIL rr_rsp: got id=%b r=%h z=%b want id=%0d", rsp_id, rsp_result, rsp_zero, (exp_ids.size() != 0) ? int'(exp_ids[0]) : -1);
        end
        $display("txn rr id=%b result=%h zero=%b", rsp_id, rsp_result, rsp_zero);
        if (exp_ids.size() != 0) void'(exp_ids.pop_front());
        rsps++;
      end
      if (r0_ready || r1_ready) begin
        g = !last;
        vectors++;
        if ({r0_ready, r1_ready} !== {!g, g}) begin
          miscompares++; $display("FAIL rr_grant%0d: got r0=%b r1=%b want grant %0d", grants, r0_ready, r1_ready, g);
        end
        exp_ids.push_back(int'(g));
        last = g; grants++;
      end
      @(posedge clk); #1;
      if (grants >= 4) begin r0_valid = 0; r1_valid = 0; end
    end
    vectors++;
    if (grants != 4 || rsps != 4) begin
      miscompares++; $display("FAIL rr_count: got %0d grants %0d rsps want 4 4", grants, rsps);
    end
  endtask

  task automatic test_backpressure();
    int t, tr, th, t1; bit ok;
    rsp_ready = 0;
    @(posedge clk); #1;
    set_req(0, 1'b1, 6'h00, 6'h20, 32'h2222, 32'h1111);
    wait_ready(0, t, ok);
    @(posedge clk); #1;
    r0_valid = 0;
    set_req(1, 1'b1, 6'h00, 6'h25, 32'h2222, 32'h1111);
    wait_rsp(tr, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL bp_rsp_timeout: got none want rsp_valid"); end
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if ({rsp_valid, rsp_id, rsp_result, rsp_zero, r0_ready, r1_ready} !== {1'b1, 1'b0, 32'h3333, 1'b0, 1'b0, 1'b0}) begin
        miscompares++; $display("FAIL bp_hold%0d: got v=%b id=%b r=%h z=%b rdy=%b%b want 1 0 3333 0 00", i, rsp_valid, rsp_id, rsp_result, rsp_zero, r0_ready, r1_ready);
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
    rsp_ready = 1;
    @(negedge clk);
    th = cyc;
    wait_ready(1, t1, ok);
    vectors++;
    if (!ok || t1 != th + 1) begin
      miscompares++; $display("FAIL bp_resume: got accept cycle %0d want %0d", t1, th + 1);
    end
    @(posedge clk); #1;
    r1_valid = 0;
    wait_rsp(tr, ok);
    vectors++;
    if (!ok || {rsp_id, rsp_result} !== {1'b1, 32'h3333}) begin
      miscompares++; $display("FAIL bp_r1_rsp: got id=%b r=%h want id=1 r=3333", rsp_id, rsp_result);
    end
    $display("txn bp id=%b result=%h zero=%b", rsp_id, rsp_result, rsp_zero);
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_exec();
    int t, tr; bit ok;
    rsp_ready = 1;
    set_req(0, 1'b1, 6'h00, 6'h20, 32'h2222, 32'h1111);
    wait_ready(0, t, ok);
    @(posedge clk); #1;                 // now in EXEC, last winner was r0
    set_req(1, 1'b1, 6'h00, 6'h22, 32'h2222, 32'h1111);
    #1 rst_n = 0;
    #1;
    vectors++;
    if ({rsp_valid, rsp_result, alu_a, alu_opcode, alu_func_field, r0_ready, r1_ready} !== '0) begin
      miscompares++; $display("FAIL midrst_vals: got v=%b r=%h a=%h op=%h fn=%h rdy=%b%b want all 0", rsp_valid, rsp_result, alu_a, alu_opcode, alu_func_field, r0_ready, r1_ready);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_rsp%0d: got rsp_valid=%b want 0", i, rsp_valid); end
    end
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    vectors++;
    if ({r0_ready, r1_ready} !== 2'b10) begin
      miscompares++; $display("FAIL midrst_grant: got r0=%b r1=%b want r0 granted", r0_ready, r1_ready);
    end
    t = cyc;
    @(posedge clk); #1;
    r0_valid = 0; r1_valid = 0;
    wait_rsp(tr, ok);
    vectors++;
    if (!ok || tr != t + 2 || {rsp_id, rsp_result} !== {1'b0, 32'h3333}) begin
      miscompares++; $display("FAIL midrst_next: got cyc=%0d id=%b r=%h want cyc=%0d id=0 r=3333", tr, rsp_id, rsp_result, t + 2);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_exec3();
    int t; bit ok;
    c_rsp_ready = 1;
    @(posedge clk); #1;
    set_req(2, 1'b1, 6'h00, 6'h20, 32'h2222, 32'h1111);
    wait_ready(2, t, ok);
    vectors++;
    if (!ok || c_r1_ready !== 1'b0) begin miscompares++; $display("FAIL ex3_accept: got ok=%0d r1_ready=%b want 1 0", ok, c_r1_ready); end
    @(posedge clk); #1;
    c_r0_valid = 0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      vectors++;
      if ({c_rsp_valid, c_alu_opcode, c_alu_func_field, c_alu_a, c_alu_b} !== {1'b0, 6'h00, 6'h20, 32'h2222, 32'h1111}) begin
        miscompares++; $display("FAIL ex3_hold%0d: got v=%b op=%h fn=%h a=%h b=%h want 0 00 20 2222 1111", k, c_rsp_valid, c_alu_opcode, c_alu_func_field, c_alu_a, c_alu_b);
      end
    end
    @(negedge clk);
    vectors++;
    if (cyc != t + 4 || {c_rsp_valid, c_rsp_id, c_rsp_result, c_rsp_zero} !== {1'b1, 1'b0, 32'h3333, 1'b0}) begin
      miscompares++; $display("FAIL ex3_rsp: got cyc=%0d v=%b r=%h want cyc=%0d v=1 r=3333", cyc, c_rsp_valid, c_rsp_result, t + 4);
    end
    $display("txn ex3 id=%b result=%h zero=%b", c_rsp_id, c_rsp_result, c_rsp_zero);
  endtask

  // Randomized traffic against a transaction-level model: at most one op
  // outstanding, round-robin on contention, response 2 cycles after accept.
  task automatic test_random();
    bit last, pend, busy, both, g, acc0, acc1;
    bit exp_r0, exp_r1, exp_rv;
    logic exp_id, exp_zero;
    logic [W-1:0] exp_res;
    int acc_cyc, txns;
    localparam int N = 1500;
    apply_reset();
    last = 1; pend = 0; txns = 0; acc_cyc = 0;
    exp_id = 0; exp_res = '0; exp_zero = 0;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      busy = pend;
      both = r0_valid && r1_valid;
      g = both ? !last : r1_valid;
      exp_r0 = !busy && r0_valid && !g;
      exp_r1 = !busy && r1_valid && g;
      vectors++;
      if ({r0_ready, r1_ready} !== {exp_r0, exp_r1}) begin
        miscompares++; $display("FAIL rnd_ready@%0d: got %b%b want %b%b", cyc, r0_ready, r1_ready, exp_r0, exp_r1);
      end
      exp_rv = pend && (cyc >= acc_cyc + 2);
      vectors++;
      if (rsp_valid !== exp_rv) begin
        miscompares++; $display("FAIL rnd_rspv@%0d: got %b want %b", cyc, rsp_valid, exp_rv);
      end
      if (exp_rv && rsp_valid) begin
        vectors++;
        if ({rsp_id, rsp_result, rsp_zero} !== {exp_id, exp_res, exp_zero}) begin
          miscompares++; $display("FAIL rnd_rsp@%0d: got id=%b r=%h z=%b want id=%b r=%h z=%b", cyc, rsp_id, rsp_result, rsp_zero, exp_id, exp_res, exp_zero);
        end
        if (rsp_ready) begin
          pend = 0; txns++;
          $display("txn rnd#%0d id=%b result=%h zero=%b", txns, rsp_id, rsp_result, rsp_zero);
        end
      end
      acc0 = exp_r0; acc1 = exp_r1;
      if (exp_r0 || exp_r1) begin
        pend = 1; acc_cyc = cyc; last = g; exp_id = g;
        if (g) {exp_res, exp_zero} = alu_fn(r1_opcode, r1_func, r1_a, r1_b);
        else   {exp_res, exp_zero} = alu_fn(r0_opcode, r0_func, r0_a, r0_b);
      end
      @(posedge clk); #1;
      if (i >= N - 12) begin
        r0_valid = 0; r1_valid = 0; rsp_ready = 1;
      end else begin
        if (acc0) begin if ($urandom_range(0, 1) == 1) rand_req(0); else r0_valid = 0; end
        else if (!r0_valid) begin if ($urandom_range(0, 2) == 0) rand_req(0); end
        else if ($urandom_range(0, 15) == 0) r0_valid = 0;
        if (acc1) begin if ($urandom_range(0, 1) == 1) rand_req(1); else r1_valid = 0; end
        else if (!r1_valid) begin if ($urandom_range(0, 2) == 0) rand_req(1); end
        else if ($urandom_range(0, 15) == 0) r1_valid = 0;
        rsp_ready = ($urandom_range(0, 4) != 0);
      end
    end
    vectors++;
    if (txns < 50 || pend) begin
      miscompares++; $display("FAIL rnd_progress: got %0d txns pend=%0d want >=50 and drained", txns, pend);
    end
  endtask

  initial begin
    test_reset();
    test_single(0, 6'h00, 6'h20, 32'h3333, 1'b0);
    test_single(1, 6'h00, 6'h24, 32'h0000, 1'b1);
    test_round_robin();
    test_backpressure();
    test_reset_mid_exec();
    test_exec3();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
